lift_motion_scheduler: RTL
==========================

Name: lift_motion_scheduler

Overview:
Sequences the single lift car by consuming the up, down and in-car request queues and deciding where the car moves, where it stops and when the door opens. It runs a collective (SCAN) policy: it serves requests in the travel direction and reverses only when nothing is left ahead. It drives the one-hot floor position and the up, down and floor clear strobes back into the request handler, closing the request/service loop.

Parameters:
N_FLOORS, 12, number of floors; one-hot width of all floor vectors
TRAVEL_CYCLES, 4, MOVE-state cycles per one-floor hop (>=1)
DOOR_CYCLES, 8, cycles the door is held open per stop (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
i_up_req_queue  in  N_FLOORS  pending hall-up requests
i_dn_req_queue  in  N_FLOORS  pending hall-down requests
i_flr_req_queue  in  N_FLOORS  pending in-car requests
o_flr_pos  out  N_FLOORS  registered one-hot car position
o_up_clr  out  1  clear-up strobe for the floor in o_flr_pos
o_dn_clr  out  1  clear-down strobe for the floor in o_flr_pos
o_flr_clr  out  1  clear-floor strobe for the floor in o_flr_pos
o_dir_up  out  1  current travel direction (1 = up)
o_moving  out  1  high while in MOVE
o_door_open  out  1  high while in DOOR

Behaviour:
- There is one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: o_flr_pos = 1 (floor 0), o_dir_up = 1, state = EVAL, counters = 0, all other outputs = 0. A reset asserted mid-move or mid-door takes effect at the next edge, with no clear strobes.
- Definitions, at current floor f:
  - all = up | dn | flr.
  - above = any bit of all at a floor > f; below = any bit of all at a floor < f.
  - ahead = above if dir_up, else below.
  - hit (dir_up) = flr[f] | up[f] | (dn[f] & ~above).
  - hit (dir_dn) = flr[f] | dn[f] | (up[f] & ~below).
- There are three states: EVAL, MOVE and DOOR.
- EVAL (one cycle per decision), in priority order:
  - hit -> DOOR.
  - ahead -> MOVE, same direction.
  - opposite side non-empty -> invert o_dir_up and go to MOVE (same edge).
  - otherwise stay in EVAL (idle).
- MOVE:
  - The travel counter increments every cycle.
  - On the edge ending the TRAVEL_CYCLES-th MOVE cycle: o_flr_pos shifts one place in the travel direction, the counter clears, and the state goes to EVAL.
  - Each hop therefore costs TRAVEL_CYCLES+1 cycles.
  - o_flr_pos never shifts past bit 0 or bit N_FLOORS-1. This is guaranteed because ahead is false at the end floors.
- DOOR entry:
  - o_door_open = 1 and the door counter = 0.
  - For exactly the first DOOR cycle: o_flr_clr = 1.
  - If dir_up: o_up_clr = 1, and o_dn_clr = 1 if ~above.
  - If dir_dn: o_dn_clr = 1, and o_up_clr = 1 if ~below.
  - o_flr_pos is stable while the strobes are high.
  - Strobing a floor with no pending bit is harmless.
- DOOR hold:
  - After DOOR_CYCLES cycles the state goes to EVAL and o_door_open drops.
  - If hit re-asserts during a DOOR cycle other than the first, the door counter restarts and the clear strobes re-pulse for one cycle (door re-open).
- o_dir_up changes only in EVAL. It is held through MOVE and DOOR.
- If requests change during MOVE, the change is only considered at the next EVAL. The car never reverses mid-hop.
- Simultaneous up[f] and dn[f] with nothing beyond f in the travel direction: both strobes pulse at the same stop.
- Counter widths are $clog2 of the respective maximum, with a minimum width of 1.

Test Plan:
- Reset: hold reset 2 cycles mid-MOVE at floor 3 -> next cycle o_flr_pos = 12'h001, o_dir_up = 1, o_moving = 0, o_door_open = 0, all strobes 0.
- Single call: idle at floor 0, flr[5] set at cycle 0 ->
  - o_moving rises at cycle 1.
  - o_flr_pos = 12'h020 at cycle 25.
  - o_door_open rises at cycle 26, with a 1-cycle o_flr_clr and o_up_clr.
  - o_door_open drops after 8 cycles.
  - Returns to idle EVAL once the queue is cleared.
- Collective up: car at floor 2 moving up, with up[4] and dn[6] pending ->
  - Stops at 4 with o_up_clr only.
  - Stops at 6 with o_up_clr and o_dn_clr (nothing above).
  - Next EVAL keeps dir until empty; a later flr[1] causes o_dir_up to fall.
- Pass-by: moving up from floor 0 with dn[3] and flr[7] ->
  - No stop at 3; stops at 7.
  - EVAL sets o_dir_up = 0, moves down and stops at 3 with o_dn_clr.
- Top boundary: flr[11] and dn[11] pending ->
  - Stops at 11 with o_flr_clr, o_up_clr and o_dn_clr in the same cycle.
  - o_flr_pos never exceeds 12'h800; idle afterwards.
- Door re-open: during door cycle 4 at floor 2 (dir up), up[2] re-asserts ->
  - o_up_clr re-pulses and the door counter restarts.
  - o_door_open stays high for 8 further cycles.

Source files
------------

// File: rtl/lift_motion_scheduler_if.sv
// Request-queue / car-status bundle between the request handler and the motion scheduler.
// The scheduler takes the master view; the request handler (or a bench) takes the slave view.
interface lift_motion_scheduler_if #(
    parameter int unsigned N_FLOORS = 12
) ();
    logic [N_FLOORS-1:0] i_up_req_queue;
    logic [N_FLOORS-1:0] i_dn_req_queue;
    logic [N_FLOORS-1:0] i_flr_req_queue;
    logic [N_FLOORS-1:0] o_flr_pos;
    logic                o_up_clr;
    logic                o_dn_clr;
    logic                o_flr_clr;
    logic                o_dir_up;
    logic                o_moving;
    logic                o_door_open;

    modport master (
        input  i_up_req_queue, i_dn_req_queue, i_flr_req_queue,
        output o_flr_pos, o_up_clr, o_dn_clr, o_flr_clr, o_dir_up, o_moving, o_door_open
    );

    modport slave (
        output i_up_req_queue, i_dn_req_queue, i_flr_req_queue,
        input  o_flr_pos, o_up_clr, o_dn_clr, o_flr_clr, o_dir_up, o_moving, o_door_open
    );
endinterface

// File: rtl/lift_motion_scheduler.sv
// Collective (SCAN) motion scheduler for a single lift car: decides moves, stops and door
// openings from the pending request queues and strobes the served requests clear.
module lift_motion_scheduler #(
    parameter int unsigned N_FLOORS      = 12,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 8
) (
    input  logic clk,
    input  logic reset,
    lift_motion_scheduler_if.master bus
);
    localparam int unsigned TRAV_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int unsigned DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TRAV_W-1:0] TRAV_LAST = TRAV_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_EVAL = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    state_t              state;
    logic [TRAV_W-1:0]   travel_cnt;
    logic [DOOR_W-1:0]   door_cnt;
    logic [N_FLOORS-1:0] flr_pos;
    logic                dir_up;
    logic                up_clr;
    logic                dn_clr;
    logic                flr_clr;
    logic                moving;
    logic                door_open;

    logic [N_FLOORS-1:0] all_req;
    logic [N_FLOORS-1:0] mask_below;
    logic [N_FLOORS-1:0] mask_above;
    logic                above;
    logic                below;
    logic                ahead;
    logic                behind;
    logic                hit;
    logic                up_here;
    logic                dn_here;
    logic                flr_here;
    logic                clr_up_sel;
    logic                clr_dn_sel;

    // Request picture relative to the current floor, plus which hall strobes a stop here would fire.
    always_comb begin
        all_req    = bus.i_up_req_queue | bus.i_dn_req_queue | bus.i_flr_req_queue;
        mask_below = flr_pos - N_FLOORS'(1);
        mask_above = ~(mask_below | flr_pos);
        above      = |(all_req & mask_above);
        below      = |(all_req & mask_below);
        up_here    = |(bus.i_up_req_queue & flr_pos);
        dn_here    = |(bus.i_dn_req_queue & flr_pos);
        flr_here   = |(bus.i_flr_req_queue & flr_pos);
        ahead      = dir_up ? above : below;
        behind     = dir_up ? below : above;
        hit        = flr_here | (dir_up ? (up_here | (dn_here & ~above))
                                        : (dn_here | (up_here & ~below)));
        clr_up_sel = dir_up | ~below;
        clr_dn_sel = ~dir_up | ~above;
    end

    // Car sequencer; clear strobes are single-cycle and default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_EVAL;
            travel_cnt <= '0;
            door_cnt   <= '0;
            flr_pos    <= N_FLOORS'(1);
            dir_up     <= 1'b1;
            up_clr     <= 1'b0;
            dn_clr     <= 1'b0;
            flr_clr    <= 1'b0;
            moving     <= 1'b0;
            door_open  <= 1'b0;
        end else begin
            up_clr  <= 1'b0;
            dn_clr  <= 1'b0;
            flr_clr <= 1'b0;
            case (state)
                ST_EVAL: begin
                    if (hit) begin
                        state     <= ST_DOOR;
                        door_cnt  <= '0;
                        door_open <= 1'b1;
                        flr_clr   <= 1'b1;
                        up_clr    <= clr_up_sel;
                        dn_clr    <= clr_dn_sel;
                    end else if (ahead) begin
                        state  <= ST_MOVE;
                        moving <= 1'b1;
                    end else if (behind) begin
                        dir_up <= ~dir_up;
                        state  <= ST_MOVE;
                        moving <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (travel_cnt == TRAV_LAST) begin
                        travel_cnt <= '0;
                        flr_pos    <= dir_up ? (flr_pos << 1) : (flr_pos >> 1);
                        state      <= ST_EVAL;
                        moving     <= 1'b0;
                    end else begin
                        travel_cnt <= travel_cnt + TRAV_W'(1);
                    end
                end
                ST_DOOR: begin
                    // The first door cycle ignores hit: its own clear strobes are still in flight.
                    if (hit && (door_cnt != '0)) begin
                        door_cnt <= '0;
                        flr_clr  <= 1'b1;
                        up_clr   <= clr_up_sel;
                        dn_clr   <= clr_dn_sel;
                    end else if (door_cnt == DOOR_LAST) begin
                        state     <= ST_EVAL;
                        door_open <= 1'b0;
                    end else begin
                        door_cnt <= door_cnt + DOOR_W'(1);
                    end
                end
                default: begin
                    state     <= ST_EVAL;
                    moving    <= 1'b0;
                    door_open <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_flr_pos   = flr_pos;
    assign bus.o_up_clr    = up_clr;
    assign bus.o_dn_clr    = dn_clr;
    assign bus.o_flr_clr   = flr_clr;
    assign bus.o_dir_up    = dir_up;
    assign bus.o_moving    = moving;
    assign bus.o_door_open = door_open;
endmodule
